// File: rtl/seg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_arb_pkg
// Description : Shared types and constants for the 7-segment display arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    localparam int NUM_REQ         = 4;
    localparam int c_DWELL_DEFAULT = 25_000_000;

    function automatic logic [3:0] nibble_sel(input logic [15:0] nibbles,
                                              input logic [1:0]  idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = nibbles[3:0];
            2'd1:    sel = nibbles[7:4];
            2'd2:    sel = nibbles[11:8];
            default: sel = nibbles[15:12];
        endcase
        return sel;
    endfunction

endpackage : seg_arb_pkg
`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational 4-way round-robin picker; search starts one
//               past the last grant and may optionally skip that index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick (
    input  logic [3:0] i_Req,
    input  logic [1:0] i_Last_Idx,
    input  logic       i_Excl_Last,
    output logic       o_Found,
    output logic [1:0] o_Winner
);

    logic [3:0] w_masked;
    logic [1:0] w_idx;

    always_comb begin
        w_masked = i_Req;
        if (i_Excl_Last) begin
            w_masked[i_Last_Idx] = 1'b0;
        end
        o_Found  = 1'b0;
        o_Winner = i_Last_Idx;
        w_idx    = 2'd0;
        // Walk from the farthest offset inward so the nearest requester wins.
        for (int k = 4; k >= 1; k--) begin
            w_idx = i_Last_Idx + 2'(k);
            if (w_masked[w_idx]) begin
                o_Found  = 1'b1;
                o_Winner = w_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Round-robin arbiter sharing the 7-seg digit between four
//               nibble producers with a fixed dwell per grant.
//               Optional blank gap between grants: SEG_ARB_BLANK_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int NUM_REQ      = seg_arb_pkg::NUM_REQ,
    parameter int DWELL_CYCLES = seg_arb_pkg::c_DWELL_DEFAULT,
    parameter int GAP_CYCLES   = 2_500_000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [4*NUM_REQ-1:0]   i_Nibbles,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic [1:0]             o_Grant_Idx,
    output logic [3:0]             o_Nibble,
    output logic                   o_Valid
);

    import seg_arb_pkg::*;

    localparam int                c_CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);

    // Only the four-requester configuration is implemented; other values
    // of the range parameters are outside the supported envelope.
    if (GAP_CYCLES < 1 || DWELL_CYCLES < 2) begin : g_param_range_unsupported
    end

    arb_state_t         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]         r_grant, w_grant_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    logic [3:0]         r_nibble, w_nibble_nxt;
    logic               r_valid, w_valid_nxt;

    logic               w_excl;
    logic               w_found;
    logic [1:0]         w_winner;
    logic               w_release;

`ifdef SEG_ARB_BLANK_GAP_EN
    localparam int                c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    logic [c_GAP_W-1:0] r_gap_cnt, w_gap_nxt;
`endif

    // In HOLD the current owner is excluded so a competitor is preferred.
    assign w_excl    = (r_state == ARB_HOLD);
    assign w_release = (r_cnt == c_DWELL_LAST) || !i_Req[r_idx];

    rr_pick u_rr_pick (
        .i_Req       (i_Req),
        .i_Last_Idx  (r_idx),
        .i_Excl_Last (w_excl),
        .o_Found     (w_found),
        .o_Winner    (w_winner)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_idx_nxt    = r_idx;
        w_nibble_nxt = r_nibble;
        w_valid_nxt  = r_valid;
`ifdef SEG_ARB_BLANK_GAP_EN
        w_gap_nxt    = r_gap_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                w_grant_nxt  = 4'b0000;
                w_nibble_nxt = 4'h0;
                w_valid_nxt  = 1'b0;
                if (w_found) begin
                    w_state_nxt  = ARB_HOLD;
                    w_cnt_nxt    = '0;
                    w_grant_nxt  = 4'b0001 << w_winner;
                    w_idx_nxt    = w_winner;
                    w_nibble_nxt = nibble_sel(i_Nibbles, w_winner);
                    w_valid_nxt  = 1'b1;
                end
            end

            ARB_HOLD: begin
                w_cnt_nxt    = r_cnt + c_CNT_W'(1);
                w_nibble_nxt = nibble_sel(i_Nibbles, r_idx);
                if (w_release) begin
                    w_cnt_nxt = '0;
                    if (w_found) begin
`ifdef SEG_ARB_BLANK_GAP_EN
                        w_state_nxt  = ARB_GAP;
                        w_gap_nxt    = '0;
                        w_grant_nxt  = 4'b0000;
                        w_nibble_nxt = 4'h0;
                        w_valid_nxt  = 1'b0;
`else
                        w_grant_nxt  = 4'b0001 << w_winner;
                        w_idx_nxt    = w_winner;
                        w_nibble_nxt = nibble_sel(i_Nibbles, w_winner);
`endif
                    end else if (!i_Req[r_idx]) begin
`ifdef SEG_ARB_BLANK_GAP_EN
                        w_state_nxt = ARB_GAP;
                        w_gap_nxt   = '0;
`else
                        w_state_nxt = ARB_IDLE;
`endif
                        w_grant_nxt  = 4'b0000;
                        w_nibble_nxt = 4'h0;
                        w_valid_nxt  = 1'b0;
                    end
                end
            end

`ifdef SEG_ARB_BLANK_GAP_EN
            ARB_GAP: begin
                w_gap_nxt = r_gap_cnt + c_GAP_W'(1);
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = ARB_IDLE;
                    if (w_found) begin
                        w_state_nxt  = ARB_HOLD;
                        w_cnt_nxt    = '0;
                        w_grant_nxt  = 4'b0001 << w_winner;
                        w_idx_nxt    = w_winner;
                        w_nibble_nxt = nibble_sel(i_Nibbles, w_winner);
                        w_valid_nxt  = 1'b1;
                    end
                end
            end
`endif

            default: begin
                w_state_nxt  = ARB_IDLE;
                w_grant_nxt  = 4'b0000;
                w_nibble_nxt = 4'h0;
                w_valid_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state  <= ARB_IDLE;
            r_cnt    <= '0;
            r_grant  <= 4'b0000;
            r_idx    <= 2'd3;
            r_nibble <= 4'h0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_idx    <= w_idx_nxt;
            r_nibble <= w_nibble_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

`ifdef SEG_ARB_BLANK_GAP_EN
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= w_gap_nxt;
        end
    end
`endif

    assign o_Grant     = r_grant;
    assign o_Grant_Idx = r_idx;
    assign o_Nibble    = r_nibble;
    assign o_Valid     = r_valid;

endmodule : seg_display_arbiter
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Directed vector bench for the display arbiter, DWELL=4, GAP=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    localparam int c_DWELL = 4;
    localparam int c_GAP   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] nibbles;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic [3:0]  nibble;
    logic        valid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  req;
        logic [15:0] nib;
        logic [3:0]  e_grant;
        logic [1:0]  e_idx;
        logic [3:0]  e_nib;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (c_DWELL),
        .GAP_CYCLES   (c_GAP)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Req       (req),
        .i_Nibbles   (nibbles),
        .o_Grant     (grant),
        .o_Grant_Idx (grant_idx),
        .o_Nibble    (nibble),
        .o_Valid     (valid)
    );

    task automatic add(input string nm, input logic r, input logic [3:0] rq,
                       input logic [15:0] nb, input logic [3:0] g,
                       input logic [1:0] ix, input logic [3:0] n, input logic v);
        vec_t t;
        t.name = nm; t.rst_n = r; t.req = rq; t.nib = nb;
        t.e_grant = g; t.e_idx = ix; t.e_nib = n; t.e_valid = v;
        vecs.push_back(t);
    endtask

    task automatic add_n(input int cnt, input string nm, input logic [3:0] rq,
                         input logic [15:0] nb, input logic [3:0] g,
                         input logic [1:0] ix, input logic [3:0] n, input logic v);
        for (int k = 0; k < cnt; k++) add(nm, 1'b1, rq, nb, g, ix, n, v);
    endtask

    task automatic check(input string nm, input logic [3:0] g, input logic [1:0] ix,
                         input logic [3:0] n, input logic v);
        n_cmp++;
        if ({grant, grant_idx, nibble, valid} !== {g, ix, n, v}) begin
            n_bad++;
            $display("FAIL %s: got grant=%b idx=%0d nib=%h valid=%b, want grant=%b idx=%0d nib=%h valid=%b",
                     nm, grant, grant_idx, nibble, valid, g, ix, n, v);
        end
    endtask

    initial begin
`ifndef SEG_ARB_BLANK_GAP_EN
        // Sole requester 2, held and re-granted without a drop, then released.
        add("t1_idle",  1'b1, 4'b0000, 16'h4A21, 4'b0000, 2'd3, 4'h0, 1'b0);
        add("t1_grant", 1'b1, 4'b0100, 16'h4A21, 4'b0100, 2'd2, 4'hA, 1'b1);
        add_n(8, "t1_hold", 4'b0100, 16'h4A21, 4'b0100, 2'd2, 4'hA, 1'b1);
        add("t1_rel",   1'b1, 4'b0000, 16'h4A21, 4'b0000, 2'd2, 4'h0, 1'b0);
        add("t1_keep",  1'b1, 4'b0000, 16'h4A21, 4'b0000, 2'd2, 4'h0, 1'b0);
        // Full rotation from a fresh reset.
        add("t2_rst",   1'b0, 4'b0000, 16'h4A21, 4'b0000, 2'd3, 4'h0, 1'b0);
        add_n(4, "t2_g0", 4'b1111, 16'h4A21, 4'b0001, 2'd0, 4'h1, 1'b1);
        add_n(4, "t2_g1", 4'b1111, 16'h4A21, 4'b0010, 2'd1, 4'h2, 1'b1);
        add_n(4, "t2_g2", 4'b1111, 16'h4A21, 4'b0100, 2'd2, 4'hA, 1'b1);
        add_n(4, "t2_g3", 4'b1111, 16'h4A21, 4'b1000, 2'd3, 4'h4, 1'b1);
        add("t2_g0b",   1'b1, 4'b1111, 16'h4A21, 4'b0001, 2'd0, 4'h1, 1'b1);
        // Owner 0 finishes dwell, 1 takes over, then drops early at dwell cycle 1.
        add_n(3, "t3_g0", 4'b0011, 16'h4A21, 4'b0001, 2'd0, 4'h1, 1'b1);
        add_n(2, "t3_g1", 4'b0011, 16'h4A21, 4'b0010, 2'd1, 4'h2, 1'b1);
        add("t3_drop",  1'b1, 4'b0001, 16'h4A21, 4'b0001, 2'd0, 4'h1, 1'b1);
        add("t3_idle",  1'b1, 4'b0000, 16'h4A21, 4'b0000, 2'd0, 4'h0, 1'b0);
        // Nibble tracking while producer 2 holds the display.
        add_n(2, "t4_g2", 4'b0100, 16'h4321, 4'b0100, 2'd2, 4'h3, 1'b1);
        add_n(3, "t4_trk", 4'b0100, 16'h4721, 4'b0100, 2'd2, 4'h7, 1'b1);
`else
        add("t6_rst",   1'b0, 4'b0000, 16'h4A21, 4'b0000, 2'd3, 4'h0, 1'b0);
        add_n(4, "t6_g0",  4'b0011, 16'h4A21, 4'b0001, 2'd0, 4'h1, 1'b1);
        add_n(2, "t6_gap", 4'b0011, 16'h4A21, 4'b0000, 2'd0, 4'h0, 1'b0);
        add_n(4, "t6_g1",  4'b0011, 16'h4A21, 4'b0010, 2'd1, 4'h2, 1'b1);
        add("t6_gap2",  1'b1, 4'b0011, 16'h4A21, 4'b0000, 2'd1, 4'h0, 1'b0);
        add("t6_gap2b", 1'b1, 4'b0100, 16'h4A21, 4'b0000, 2'd1, 4'h0, 1'b0);
        // Sole requester is re-granted across dwell boundaries without a gap.
        add_n(6, "t6_sole", 4'b0100, 16'h4A21, 4'b0100, 2'd2, 4'hA, 1'b1);
        add("t6_rel",   1'b1, 4'b0000, 16'h4A21, 4'b0000, 2'd2, 4'h0, 1'b0);
        add_n(2, "t6_gidl", 4'b0000, 16'h4A21, 4'b0000, 2'd2, 4'h0, 1'b0);
        add_n(3, "t4_g2",  4'b0100, 16'h4721, 4'b0100, 2'd2, 4'h7, 1'b1);
`endif

        rst_n   = 1'b0;
        req     = 4'b0000;
        nibbles = 16'h4A21;
        #12;
        check("reset_state", 4'b0000, 2'd3, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            req     = vecs[i].req;
            nibbles = vecs[i].nib;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].e_grant, vecs[i].e_idx, vecs[i].e_nib, vecs[i].e_valid);
        end

        // Asynchronous reset in the middle of producer 2's dwell.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_rst", 4'b0000, 2'd3, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        @(posedge clk);
        #1;
        check("t5_regrant3", 4'b1000, 2'd3, 4'h4, 1'b1);
        @(posedge clk);
        #1;
        check("t5_hold3", 4'b1000, 2'd3, 4'h4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seg_display_arbiter
`default_nettype wire

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 7-segment digit and the 4 LEDs between up to four nibble producers: auto counter, switch counter, bit counter and a spare.
- Each producer raises a request. The arbiter grants the display round-robin, holds each grant for a configurable dwell time, and outputs the selected nibble.
- Sits between the counters and the nibble-to-7-segment converter. It replaces the fixed mode-driven nibble mux.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed at 4 in this revision; other values are unsupported.
- DWELL_CYCLES, 25_000_000, clock cycles one grant is held, 1 s at 25 MHz. Minimum 2.
- GAP_CYCLES, 2_500_000, blank cycles between grants. Used only when SEG_ARB_BLANK_GAP_EN is defined. Minimum 1.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Req  in  4  request per producer; bit k = producer k
- i_Nibbles  in  16  producer nibbles; bits [4k+3:4k] = producer k
- o_Grant  out  4  one-hot grant, or all zeros
- o_Grant_Idx  out  2  index of the current or last grant
- o_Nibble  out  4  registered nibble of the granted producer
- o_Valid  out  1  high while o_Nibble is meaningful; downstream blanks the display when low

Behaviour:
- Reset, asynchronous, while i_Rst_L=0:
  - o_Grant=0, o_Grant_Idx=3, o_Nibble=0, o_Valid=0, dwell counter=0, state=IDLE.
  - Last-grant pointer=3, so index 0 has first priority.
  - Deassertion mid-grant returns to IDLE; no grant survives reset.
- States: IDLE, HOLD, GAP (GAP exists only with the feature macro).
- Round-robin pick: search i_Req starting at (last_idx+1) mod 4, wrapping. The first set bit wins.
- IDLE:
  - If i_Req == 0, stay; outputs 0, o_Valid=0.
  - Else, on the next edge: pick winner w, o_Grant=1<<w, o_Grant_Idx=w, o_Nibble=i_Nibbles[w], o_Valid=1, counter=0, go to HOLD.
  - Latency: one cycle from request to grant.
- HOLD:
  - Each cycle, o_Nibble <= i_Nibbles[o_Grant_Idx] (1-cycle tracking latency). Counter increments.
  - Expiry, when counter == DWELL_CYCLES-1:
    - Pick among i_Req excluding the current index.
    - If another requester exists, switch to it on the next edge (or via GAP with the feature). Counter=0.
    - If only the current requester is still asserted, re-grant it and restart the counter. o_Grant stays high with no glitch.
    - If no requests remain, go to IDLE: o_Grant=0, o_Valid=0, o_Nibble=0.
  - Early release, current i_Req bit drops before expiry:
    - Treated exactly as expiry on that same cycle.
    - The dropped requester is never shown again until it re-requests.
  - A release and a new request in the same cycle resolve like expiry. The new requester is eligible that cycle.
- New requests during HOLD never preempt; they wait for expiry or release.
- Starvation bound: any asserted requester is granted within 3 dwell periods (plus gaps).
- Counter width: $clog2(DWELL_CYCLES). Must not wrap; it is compared with == and reset on every grant change.
- The grant is always one-hot or zero. o_Grant_Idx holds its last value in IDLE.

Optional Feature:
- Macro: SEG_ARB_BLANK_GAP_EN.
- Defined:
  - Every grant change and every HOLD->IDLE passes through GAP for GAP_CYCLES: o_Grant=0, o_Valid=0, o_Nibble=0.
  - The winner is picked at GAP exit from the then-current i_Req. If nothing is requested, go to IDLE.
  - Re-granting the same sole requester skips GAP.
- Undefined:
  - GAP state and GAP_CYCLES logic are absent; switches are back-to-back in one edge.

Decomposition:
- Package seg_arb_pkg holds:
  - state encodings ARB_IDLE=2'd0, ARB_HOLD=2'd1, ARB_GAP=2'd2;
  - localparam NUM_REQ=4;
  - a default DWELL constant.
- One sub-module, rr_pick:
  - combinational round-robin picker;
  - inputs: 4-bit request, 2-bit last index, 1-bit exclude-last flag;
  - outputs: found flag, 2-bit winner.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2 where enabled):
1. Reset, then i_Req=4'b0100 with i_Nibbles[11:8]=4'hA. Expect o_Grant=4'b0100, o_Nibble=4'hA, o_Valid=1 one cycle after the request. The grant is held continuously and re-granted every 4 cycles with no drop.
2. i_Req=4'b1111 from IDLE, all held. Expect grants in order 0,1,2,3,0, each exactly 4 cycles. o_Grant_Idx follows 0,1,2,3,0.
3. Producer 1 granted; i_Req=4'b0011 drops bit 1 at dwell cycle 1. Expect the grant to move to index 0 on the next edge, and o_Nibble to show producer 0's nibble.
4. Producer 2 granted; change i_Nibbles[11:8] from 4'h3 to 4'h7 mid-dwell. Expect o_Nibble=4'h7 exactly one cycle later; the grant is unchanged.
5. i_Rst_L pulled low mid-HOLD. Expect o_Grant=0, o_Valid=0 and o_Nibble=0 immediately (asynchronous). After release with i_Req=4'b1000, index 3 is granted.
6. SEG_ARB_BLANK_GAP_EN defined, i_Req=4'b0011. Expect 4 cycles idx0, 2 cycles o_Valid=0 with o_Grant=0, then 4 cycles idx1.
